// File: rtl/seq_code_tx.sv
`default_nettype none
// ============================================================================
// Module  : seq_code_tx
// Brief   : Plays a stored N-digit code onto a digit bus one digit at a time,
//           with programmable hold/gap timing and a start/busy/done handshake.
//           Optional build macro SEQ_CODE_TX_REPEAT_EN adds input repeat_en
//           for continuous replay of the captured code.
// Revision: 1.0  initial release
// ============================================================================
module seq_code_tx #(
    parameter int DIGIT_W     = 3,
    parameter int N_DIGITS    = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0,
    parameter int IDLE_DIGIT  = 6
) (
    input  logic                         clk,
    input  logic                         clear,
`ifdef SEQ_CODE_TX_REPEAT_EN
    input  logic                         repeat_en,
`endif
    input  logic                         start,
    input  logic [N_DIGITS*DIGIT_W-1:0]  code,
    output logic [DIGIT_W-1:0]           out_digit,
    output logic                         digit_valid,
    output logic [3:0]                   digit_idx,
    output logic                         busy,
    output logic                         done
);

    localparam logic [DIGIT_W-1:0] IDLE_V    = DIGIT_W'(IDLE_DIGIT);
    localparam logic [3:0]         LAST_IDX  = 4'(N_DIGITS - 1);
    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]         GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam bit                 HAS_GAP   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                        state;
    logic [N_DIGITS*DIGIT_W-1:0]   code_q;
    logic [7:0]                    cnt;
    logic                          rpt_q;
    logic                          do_repeat;
    logic [3:0]                    nxt_idx;
    logic [DIGIT_W-1:0]            digits [16];

`ifdef SEQ_CODE_TX_REPEAT_EN
    assign do_repeat = repeat_en;
`else
    assign do_repeat = 1'b0;
`endif

    assign nxt_idx = digit_idx + 4'd1;

    // Digit table over the captured code; slots beyond N_DIGITS are never addressed.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_digits
            if (gi < N_DIGITS) begin : g_used
                assign digits[gi] = code_q[(N_DIGITS-1-gi)*DIGIT_W +: DIGIT_W];
            end else begin : g_unused
                assign digits[gi] = IDLE_V;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= S_IDLE;
            code_q      <= '0;
            cnt         <= 8'd0;
            rpt_q       <= 1'b0;
            out_digit   <= IDLE_V;
            digit_valid <= 1'b0;
            digit_idx   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= S_SEND;
                        code_q      <= code;
                        cnt         <= 8'd0;
                        digit_idx   <= 4'd0;
                        out_digit   <= code[N_DIGITS*DIGIT_W-1 -: DIGIT_W];
                        digit_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= 8'd0;
                        if (digit_idx == LAST_IDX) begin
                            state       <= S_DONE;
                            out_digit   <= IDLE_V;
                            digit_valid <= 1'b0;
                            done        <= 1'b1;
                            busy        <= do_repeat;
                            rpt_q       <= do_repeat;
                        end else if (HAS_GAP) begin
                            state       <= S_GAP;
                            out_digit   <= IDLE_V;
                            digit_valid <= 1'b0;
                        end else begin
                            digit_idx   <= nxt_idx;
                            out_digit   <= digits[nxt_idx];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state       <= S_SEND;
                        cnt         <= 8'd0;
                        digit_idx   <= nxt_idx;
                        out_digit   <= digits[nxt_idx];
                        digit_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    done <= 1'b0;
                    cnt  <= 8'd0;
                    // Replay restarts from the code captured at the original start.
                    if (rpt_q) begin
                        state       <= S_SEND;
                        digit_idx   <= 4'd0;
                        out_digit   <= digits[0];
                        digit_valid <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    out_digit   <= IDLE_V;
                    digit_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
